// File: rtl/bp_pkg.sv
// Shared types and default widths for the branch predictor front end.
package bp_pkg;

    localparam int unsigned BP_IDX_W  = 10;
    localparam int unsigned BP_HIST_W = 10;
    localparam int unsigned BP_DEPTH  = 4;

    typedef logic [BP_IDX_W-1:0] bp_idx_t;

    typedef struct packed {
        bp_idx_t               idx;
        logic                  pred;
        logic [BP_HIST_W-1:0]  snap;
    } bhq_entry_t;

endpackage

// File: rtl/bhq_fifo.sv
// Generic DEPTH-entry synchronous FIFO with single-cycle flush; head data read combinationally.
module bhq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c, do_pop_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[head_q];
    assign do_push_c = push_i & !full_o;
    assign do_pop_c  = pop_i & !empty_o;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push_c) tail_d = tail_q + PTR_W'(1);
            if (do_pop_c)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (do_push_c && !flush_i) mem_q[tail_q] <= wdata_i;
    end

endmodule

// File: rtl/branch_history_queue.sv
// In-order queue of in-flight predicted branches feeding the 2-bit predictor table.
// Define BHQ_GSHARE_EN for gshare indexing with a repaired global history register.
module branch_history_queue
    import bp_pkg::*;
#(
    parameter int unsigned IDX_W  = BP_IDX_W,
    parameter int unsigned DEPTH  = BP_DEPTH,
    parameter int unsigned HIST_W = BP_HIST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              fetch_pc,
    input  logic                     fetch_is_br,
    output logic [IDX_W-1:0]         pt_idx,
    output logic                     pt_read,
    input  logic                     pt_pred,
    output logic                     enq_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     mispredict,
    output logic                     upd_write,
    output logic [IDX_W-1:0]         upd_idx,
    output logic                     upd_outcome,
    output logic [$clog2(DEPTH):0]   occupancy
);

`ifdef BHQ_GSHARE_EN
    localparam int unsigned ENTRY_W = $bits(bhq_entry_t);
`else
    localparam int unsigned ENTRY_W = BP_IDX_W + 1;
`endif

    logic               full_c, empty_c, resolve_c, push_c;
    logic [ENTRY_W-1:0] wdata_c, rdata_c;
    logic [IDX_W-1:0]   pc_idx_c, head_idx_c;
    logic               head_pred_c;
    logic               unused_pc_c;

    logic               upd_write_q, upd_write_d;
    logic [IDX_W-1:0]   upd_idx_q, upd_idx_d;
    logic               upd_outcome_q, upd_outcome_d;

    assign pc_idx_c    = fetch_pc[IDX_W+1:2];
    assign unused_pc_c = ^{fetch_pc[31:IDX_W+2], fetch_pc[1:0]};

    // Ready depends only on registered occupancy, never on this cycle's resolve.
    assign enq_ready  = !full_c;
    assign pt_read    = fetch_is_br & enq_ready;
    assign resolve_c  = res_valid & !empty_c;
    assign mispredict = resolve_c & (head_pred_c != res_taken);
    assign push_c     = pt_read & !mispredict;

`ifdef BHQ_GSHARE_EN
    logic [HIST_W-1:0] ghr_q, ghr_d;
    bhq_entry_t        wr_ent_c, rd_ent_c;

    assign pt_idx = pc_idx_c ^ IDX_W'(ghr_q);

    always_comb begin
        wr_ent_c      = '0;
        wr_ent_c.idx  = bp_idx_t'(pt_idx);
        wr_ent_c.pred = pt_pred;
        wr_ent_c.snap = BP_HIST_W'(ghr_q);
    end

    assign wdata_c     = wr_ent_c;
    assign rd_ent_c    = rdata_c;
    assign head_idx_c  = IDX_W'(rd_ent_c.idx);
    assign head_pred_c = rd_ent_c.pred;

    // Speculative shift on enqueue; rebuild from the head snapshot on mispredict.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict)  ghr_d = HIST_W'({HIST_W'(rd_ent_c.snap), res_taken});
        else if (push_c) ghr_d = HIST_W'({ghr_q, pt_pred});
    end

    always_ff @(posedge clk) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end
`else
    localparam int unsigned unused_hist_w = HIST_W;

    assign pt_idx      = pc_idx_c;
    assign wdata_c     = {BP_IDX_W'(pc_idx_c), pt_pred};
    assign head_idx_c  = IDX_W'(rdata_c[ENTRY_W-1:1]);
    assign head_pred_c = rdata_c[0];
`endif

    bhq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (resolve_c),
        .flush_i (mispredict),
        .wdata_i (wdata_c),
        .rdata_o (rdata_c),
        .full_o  (full_c),
        .empty_o (empty_c),
        .count_o (occupancy)
    );

    // One table write per resolved branch, one cycle after resolution.
    always_comb begin
        upd_write_d   = resolve_c;
        upd_idx_d     = upd_idx_q;
        upd_outcome_d = upd_outcome_q;
        if (resolve_c) begin
            upd_idx_d     = head_idx_c;
            upd_outcome_d = res_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_write_q   <= 1'b0;
            upd_idx_q     <= '0;
            upd_outcome_q <= 1'b0;
        end else begin
            upd_write_q   <= upd_write_d;
            upd_idx_q     <= upd_idx_d;
            upd_outcome_q <= upd_outcome_d;
        end
    end

    assign upd_write   = upd_write_q;
    assign upd_idx     = upd_idx_q;
    assign upd_outcome = upd_outcome_q;

endmodule

// File: tb/tb_branch_history_queue.sv
// Randomized and directed bench for branch_history_queue against a queue-based reference model.
module tb_branch_history_queue;

    localparam int unsigned IDX_W  = 10;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned HIST_W = 10;
    localparam int unsigned IMASK  = (1 << IDX_W) - 1;
    localparam int unsigned HMASK  = (1 << HIST_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [31:0]             fetch_pc;
    logic                    fetch_is_br;
    logic [IDX_W-1:0]        pt_idx;
    logic                    pt_read;
    logic                    pt_pred;
    logic                    enq_ready;
    logic                    res_valid;
    logic                    res_taken;
    logic                    mispredict;
    logic                    upd_write;
    logic [IDX_W-1:0]        upd_idx;
    logic                    upd_outcome;
    logic [$clog2(DEPTH):0]  occupancy;

    always #5 clk = ~clk;

    branch_history_queue #(.IDX_W(IDX_W), .DEPTH(DEPTH), .HIST_W(HIST_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_pc    (fetch_pc),
        .fetch_is_br (fetch_is_br),
        .pt_idx      (pt_idx),
        .pt_read     (pt_read),
        .pt_pred     (pt_pred),
        .enq_ready   (enq_ready),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .mispredict  (mispredict),
        .upd_write   (upd_write),
        .upd_idx     (upd_idx),
        .upd_outcome (upd_outcome),
        .occupancy   (occupancy)
    );

    typedef struct {
        int unsigned idx;
        bit          pred;
        int unsigned snap;
    } ent_t;

    ent_t        q[$];
    int unsigned ghr  = 0;
    bit          e_uw = 0;
    int unsigned e_ui = 0;
    bit          e_uo = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int unsigned model_idx(input logic [31:0] pc);
        int unsigned r;
        r = (int'(pc) >> 2) & IMASK;
`ifdef BHQ_GSHARE_EN
        r = r ^ ghr;
`endif
        return r;
    endfunction

    // Apply inputs after the falling edge and compare every output with the model.
    task automatic drive(input logic [31:0] pc, input bit br, input bit pred,
                         input bit rv, input bit rt, input bit r);
        bit ready, res, mp;
        fetch_pc    = pc;
        fetch_is_br = br;
        pt_pred     = pred;
        res_valid   = rv;
        res_taken   = rt;
        rst         = r;
        #1;
        ready = (q.size() < DEPTH);
        res   = rv && (q.size() != 0);
        mp    = res && (q[0].pred != rt);
        check("enq_ready",   64'(enq_ready),   64'(ready));
        check("pt_read",     64'(pt_read),     64'(br && ready));
        check("pt_idx",      64'(pt_idx),      64'(model_idx(pc)));
        check("mispredict",  64'(mispredict),  64'(mp));
        check("occupancy",   64'(occupancy),   64'(q.size()));
        check("upd_write",   64'(upd_write),   64'(e_uw));
        check("upd_idx",     64'(upd_idx),     64'(e_ui));
        check("upd_outcome", 64'(upd_outcome), 64'(e_uo));
    endtask

    // Advance the model across the coming rising edge, then wait for the next falling edge.
    task automatic commit();
        bit ready, res, mp;
        int unsigned idx;
        ready = (q.size() < DEPTH);
        res   = res_valid && (q.size() != 0);
        mp    = res && (q[0].pred != res_taken);
        idx   = model_idx(fetch_pc);
        if (rst) begin
            q.delete();
            ghr  = 0;
            e_uw = 0;
            e_ui = 0;
            e_uo = 0;
        end else begin
            e_uw = res;
            if (res) begin
                e_ui = q[0].idx;
                e_uo = res_taken;
            end
            if (mp) begin
`ifdef BHQ_GSHARE_EN
                ghr = ((q[0].snap << 1) | int'(res_taken)) & HMASK;
`endif
                q.delete();
            end else begin
                if (res) void'(q.pop_front());
                if (fetch_is_br && ready) begin
                    q.push_back('{idx, pt_pred, ghr});
`ifdef BHQ_GSHARE_EN
                    ghr = ((ghr << 1) | int'(pt_pred)) & HMASK;
`endif
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic [31:0] pc, input bit br, input bit pred,
                        input bit rv, input bit rt, input bit r);
        drive(pc, br, pred, rv, rt, r);
        commit();
    endtask

    initial begin
        rst = 1'b1; fetch_pc = '0; fetch_is_br = 0; pt_pred = 0; res_valid = 0; res_taken = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Reset mid-stream with three live entries.
        for (int i = 0; i < 3; i++) step($urandom, 1, 1'($urandom), 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        check("rst_occ",   64'(occupancy), 64'd0);
        check("rst_uw",    64'(upd_write), 64'd0);
        check("rst_ready", 64'(enq_ready), 64'd1);
        check("rst_ghr",   64'(pt_idx),    64'd0);
        commit();

        // Single branch, correctly predicted taken.
        drive(32'h0000_1234, 1, 1, 0, 0, 0);
        check("bim_idx", 64'(pt_idx), 64'h08D);
        commit();
        drive(0, 0, 0, 1, 1, 0);
        check("bim_mp", 64'(mispredict), 64'd0);
        commit();
        drive(0, 0, 0, 0, 0, 0);
        check("bim_uw", 64'(upd_write),   64'd1);
        check("bim_ui", 64'(upd_idx),     64'h08D);
        check("bim_uo", 64'(upd_outcome), 64'd1);
        commit();

        // Fill to DEPTH; same-cycle pop must not raise ready.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step($urandom, 1, 1, 0, 0, 0);
        drive(32'h100, 1, 1, 0, 0, 0);
        check("full_ready", 64'(enq_ready), 64'd0);
        check("full_read",  64'(pt_read),   64'd0);
        commit();
        drive(32'h100, 1, 1, 1, 1, 0);
        check("full_pop_ready", 64'(enq_ready), 64'd0);
        commit();
        drive(32'h100, 0, 0, 0, 0, 0);
        check("after_pop_ready", 64'(enq_ready), 64'd1);
        check("after_pop_occ",   64'(occupancy), 64'(DEPTH - 1));
        commit();

        // Mispredict flush with a same-cycle enqueue.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step($urandom, 1, 0, 0, 0, 0);
        drive(32'h200, 1, 1, 1, 1, 0);
        check("flush_mp", 64'(mispredict), 64'd1);
        commit();
        drive(0, 0, 0, 0, 0, 0);
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_uw",  64'(upd_write), 64'd1);
        commit();
        drive(0, 0, 0, 0, 0, 0);
        check("flush_one_write", 64'(upd_write), 64'd0);
        commit();

`ifdef BHQ_GSHARE_EN
        // History folding and repair.
        step(0, 0, 0, 0, 0, 1);
        drive(32'h40, 1, 1, 0, 0, 0);
        check("gs_idx0", 64'(pt_idx), 64'h010);
        commit();
        drive(32'h40, 0, 0, 0, 0, 0);
        check("gs_idx1", 64'(pt_idx), 64'h011);
        commit();
        drive(32'h40, 0, 0, 1, 0, 0);
        check("gs_mp", 64'(mispredict), 64'd1);
        commit();
        drive(32'h40, 0, 0, 0, 0, 0);
        check("gs_repair", 64'(pt_idx), 64'h010);
        commit();
`endif

        // Resolve against an empty queue.
        step(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1, 0);
        check("empty_mp", 64'(mispredict), 64'd0);
        commit();
        drive(0, 0, 0, 0, 0, 0);
        check("empty_uw",  64'(upd_write), 64'd0);
        check("empty_occ", 64'(occupancy), 64'd0);
        commit();

        // Random traffic; outcomes usually agree with the head prediction.
        for (int i = 0; i < 3000; i++) begin
            bit br, pred, rv, rt, r;
            br   = ($urandom_range(0, 9) < 6);
            pred = 1'($urandom);
            rv   = 1'($urandom);
            rt   = (q.size() != 0 && $urandom_range(0, 3) != 0) ? q[0].pred : 1'($urandom);
            r    = ($urandom_range(0, 199) == 0);
            step($urandom, br, pred, rv, rt, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
